// File: rtl/branch_resolve_unit_pkg.sv
// Shared CPU definitions for the ID-stage branch resolution logic.
// Holds widths, outcome-class encodings and the resolver FSM states.
package pkg_cpu_defs;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;
  localparam int CNT_W   = 16;

  localparam logic [2:0] CASE_A = 3'd0;
  localparam logic [2:0] CASE_B = 3'd1;
  localparam logic [2:0] CASE_C = 3'd2;
  localparam logic [2:0] CASE_D = 3'd3;
  localparam logic [2:0] CASE_E = 3'd4;

  typedef enum logic {
    ST_IDLE,
    ST_HELD
  } bru_state_e;

  function automatic logic is_mispred(input logic [2:0] c);
    return (c == CASE_B) || (c == CASE_C) || (c == CASE_D);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter used for the branch debug statistics.
// Sticks at all-ones instead of wrapping.
module bru_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolver: checks the BTB guess against the decoder,
// redirects fetch and trains the BTB once per mispredicted instruction.
module branch_resolve_unit #(
  parameter int XLEN    = pkg_cpu_defs::XLEN,
  parameter int PC_STEP = pkg_cpu_defs::PC_STEP,
  parameter int CNT_W   = pkg_cpu_defs::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic             stall,
  input  logic [XLEN-1:0]  pc_if,
  input  logic             btb_hit,
  input  logic [XLEN-1:0]  btb_pred_pc,
  input  logic             id_is_bj,
  input  logic             id_taken,
  input  logic [XLEN-1:0]  id_target,
  output logic             btb_ren,
  output logic             btb_wen,
  output logic [XLEN-1:0]  btb_upd_pc,
  output logic [XLEN-1:0]  btb_upd_target,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if,
  output logic [CNT_W-1:0] bj_cnt,
  output logic [CNT_W-1:0] mp_cnt
);
  import pkg_cpu_defs::*;

  logic            id_valid_q, id_valid_d;
  logic            hit_q, hit_d;
  logic [XLEN-1:0] pc_id_q, pc_id_d;
  logic [XLEN-1:0] pred_q, pred_d;

  bru_state_e      state_q, state_d;
  logic            hold_wen_q, hold_wen_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] hold_tgt_q, hold_tgt_d;

  logic [2:0]      cls;
  logic            bj_taken;
  logic            mispred;
  logic            live_wen;
  logic [XLEN-1:0] live_pc;

  logic            rd_w;
  logic            wen_w;
  logic [XLEN-1:0] rpc_w;
  logic [XLEN-1:0] tgt_w;

  always_comb begin
    bj_taken = id_is_bj & id_taken;
    cls      = CASE_E;
    unique case (1'b1)
      hit_q & bj_taken & (id_target == pred_q): cls = CASE_A;
      hit_q & bj_taken & (id_target != pred_q): cls = CASE_B;
      hit_q & !bj_taken:                        cls = CASE_C;
      !hit_q & bj_taken:                        cls = CASE_D;
      default:                                  cls = CASE_E;
    endcase
    mispred  = id_valid_q & is_mispred(cls);
    live_wen = (cls == CASE_B) || (cls == CASE_D);
    live_pc  = (cls == CASE_C) ? pc_id_q + XLEN'(PC_STEP)
                               : id_target;
  end

  // A decision seen under stall is parked so it fires once on release.
  always_comb begin
    state_d    = state_q;
    hold_wen_d = hold_wen_q;
    hold_pc_d  = hold_pc_q;
    hold_tgt_d = hold_tgt_q;
    rd_w       = 1'b0;
    wen_w      = 1'b0;
    rpc_w      = live_pc;
    tgt_w      = id_target;
    unique case (state_q)
      ST_IDLE: begin
        if (mispred && stall) begin
          state_d    = ST_HELD;
          hold_wen_d = live_wen;
          hold_pc_d  = live_pc;
          hold_tgt_d = id_target;
        end else if (mispred) begin
          rd_w  = 1'b1;
          wen_w = live_wen;
        end
      end
      ST_HELD: begin
        if (!stall) begin
          rd_w    = 1'b1;
          wen_w   = hold_wen_q;
          rpc_w   = hold_pc_q;
          tgt_w   = hold_tgt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    id_valid_d = id_valid_q;
    hit_d      = hit_q;
    pc_id_d    = pc_id_q;
    pred_d     = pred_q;
    if (rd_w) begin
      id_valid_d = 1'b0;
    end else if (!stall) begin
      id_valid_d = if_valid;
      hit_d      = btb_hit;
      pc_id_d    = pc_if;
      pred_d     = btb_pred_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      hit_q      <= 1'b0;
      pc_id_q    <= '0;
      pred_q     <= '0;
      state_q    <= ST_IDLE;
      hold_wen_q <= 1'b0;
      hold_pc_q  <= '0;
      hold_tgt_q <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      hit_q      <= hit_d;
      pc_id_q    <= pc_id_d;
      pred_q     <= pred_d;
      state_q    <= state_d;
      hold_wen_q <= hold_wen_d;
      hold_pc_q  <= hold_pc_d;
      hold_tgt_q <= hold_tgt_d;
    end
  end

  assign btb_ren        = if_valid & ~stall;
  assign redirect       = rd_w;
  assign flush_if       = rd_w;
  assign redirect_pc    = rd_w ? rpc_w : '0;
  assign btb_wen        = wen_w;
  assign btb_upd_pc     = wen_w ? pc_id_q : '0;
  assign btb_upd_target = wen_w ? tgt_w : '0;

  // A redirect fires exactly when a mispredicted instruction leaves ID.
  bru_sat_counter #(.W(CNT_W)) u_bj_cnt (
    .clk (clk),
    .rst (rst),
    .inc (id_valid_q & ~stall & id_is_bj),
    .cnt (bj_cnt)
  );

  bru_sat_counter #(.W(CNT_W)) u_mp_cnt (
    .clk (clk),
    .rst (rst),
    .inc (rd_w),
    .cnt (mp_cnt)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stimulus queues expected
// redirect/update pulses, a negedge monitor pops and compares them.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, stall, btb_hit, id_is_bj, id_taken;
  logic [31:0] pc_if, btb_pred_pc, id_target;

  logic        btb_ren, btb_wen, redirect, flush_if;
  logic [31:0] btb_upd_pc, btb_upd_target, redirect_pc;
  logic [15:0] bj_cnt, mp_cnt;

  logic        s_btb_ren, s_btb_wen, s_redirect, s_flush_if;
  logic [31:0] s_btb_upd_pc, s_btb_upd_target, s_redirect_pc;
  logic [2:0]  s_bj_cnt, s_mp_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        wen;
    logic [31:0] upc;
    logic [31:0] utg;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .stall(stall),
    .pc_if(pc_if), .btb_hit(btb_hit), .btb_pred_pc(btb_pred_pc),
    .id_is_bj(id_is_bj), .id_taken(id_taken), .id_target(id_target),
    .btb_ren(btb_ren), .btb_wen(btb_wen), .btb_upd_pc(btb_upd_pc),
    .btb_upd_target(btb_upd_target), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush_if(flush_if),
    .bj_cnt(bj_cnt), .mp_cnt(mp_cnt)
  );

  branch_resolve_unit #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .if_valid(if_valid), .stall(stall),
    .pc_if(pc_if), .btb_hit(btb_hit), .btb_pred_pc(btb_pred_pc),
    .id_is_bj(id_is_bj), .id_taken(id_taken), .id_target(id_target),
    .btb_ren(s_btb_ren), .btb_wen(s_btb_wen),
    .btb_upd_pc(s_btb_upd_pc), .btb_upd_target(s_btb_upd_target),
    .redirect(s_redirect), .redirect_pc(s_redirect_pc),
    .flush_if(s_flush_if), .bj_cnt(s_bj_cnt), .mp_cnt(s_mp_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [31:0] pc, input logic wen,
                           input logic [31:0] upc,
                           input logic [31:0] utg);
    exp_t e;
    e.pc  = pc;
    e.wen = wen;
    e.upc = upc;
    e.utg = utg;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic ifv, input logic st,
                      input logic [31:0] pc, input logic h,
                      input logic [31:0] pr, input logic bj,
                      input logic tk, input logic [31:0] tg);
    if_valid    = ifv;
    stall       = st;
    pc_if       = pc;
    btb_hit     = h;
    btb_pred_pc = pr;
    id_is_bj    = bj;
    id_taken    = tk;
    id_target   = tg;
    @(posedge clk);
    #1;
  endtask

  task automatic cnts(input string name, input logic [15:0] bj,
                      input logic [15:0] mp, input logic [2:0] sbj,
                      input logic [2:0] smp);
    chk({name, " bj_cnt"}, 32'(bj_cnt), 32'(bj));
    chk({name, " mp_cnt"}, 32'(mp_cnt), 32'(mp));
    chk({name, " small bj_cnt"}, 32'(s_bj_cnt), 32'(sbj));
    chk({name, " small mp_cnt"}, 32'(s_mp_cnt), 32'(smp));
  endtask

  task automatic drained(input string name);
    chk({name, " pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (redirect || btb_wen || s_redirect || s_btb_wen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_pulse redirect=%0b wen=%0b pc=%0h expected=none",
                 redirect, btb_wen, redirect_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (redirect !== 1'b1 || flush_if !== 1'b1 ||
            redirect_pc !== e.pc || btb_wen !== e.wen ||
            s_redirect !== 1'b1 || s_redirect_pc !== e.pc ||
            s_btb_wen !== e.wen ||
            (e.wen && (btb_upd_pc !== e.upc ||
                       btb_upd_target !== e.utg))) begin
          errors++;
          $display("FAIL pulse actual rd=%0b fl=%0b pc=%0h wen=%0b upc=%0h utg=%0h expected pc=%0h wen=%0b upc=%0h utg=%0h",
                   redirect, flush_if, redirect_pc, btb_wen,
                   btb_upd_pc, btb_upd_target,
                   e.pc, e.wen, e.upc, e.utg);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    if_valid = 0; stall = 0; pc_if = 0; btb_hit = 0;
    btb_pred_pc = 0; id_is_bj = 0; id_taken = 0; id_target = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset redirect", 32'(redirect), 0);
    chk("reset btb_wen", 32'(btb_wen), 0);
    chk("reset redirect_pc", redirect_pc, 0);
    cnts("reset", 0, 0, 0, 0);
    rst = 1'b0;

    if_valid = 1; stall = 1;
    #1 chk("btb_ren stalled", 32'(btb_ren), 0);
    stall = 0;
    #1 chk("btb_ren active", 32'(btb_ren), 1);

    // 1: BTB miss, taken jump
    step(1, 0, 32'h100, 0, 0, 0, 0, 0);
    expect_ev(32'h400, 1, 32'h100, 32'h400);
    step(0, 0, 0, 0, 0, 1, 1, 32'h400);
    drained("t1");
    cnts("t1", 1, 1, 1, 1);

    // 2: correct prediction
    step(1, 0, 32'h200, 1, 32'h380, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h380);
    drained("t2");
    cnts("t2", 2, 1, 2, 1);

    // 3: hit but branch not taken
    step(1, 0, 32'h300, 1, 32'h500, 0, 0, 0);
    expect_ev(32'h304, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'h500);
    drained("t3");
    cnts("t3", 3, 2, 3, 2);

    // 4: wrong target held under a 3-cycle stall
    step(1, 0, 32'h600, 1, 32'h700, 0, 0, 0);
    repeat (3) step(1, 1, 32'h604, 0, 0, 1, 1, 32'h800);
    drained("t4 stalled");
    cnts("t4 stalled", 3, 2, 3, 2);
    expect_ev(32'h800, 1, 32'h600, 32'h800);
    step(0, 0, 0, 0, 0, 1, 1, 32'h800);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    drained("t4");
    cnts("t4", 4, 3, 4, 3);

    // 5: redirect squashes the instruction in IF
    step(1, 0, 32'h900, 0, 0, 0, 0, 0);
    expect_ev(32'hC00, 1, 32'h900, 32'hC00);
    step(1, 0, 32'hA00, 0, 0, 1, 1, 32'hC00);
    step(0, 0, 0, 0, 0, 1, 1, 32'hD00);
    drained("t5");
    cnts("t5", 5, 4, 5, 4);

    // fall-through wraps at the top of the address space
    step(1, 0, 32'hFFFF_FFFC, 1, 32'h40, 0, 0, 0);
    expect_ev(32'h0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    drained("wrap");
    cnts("wrap", 5, 5, 5, 5);

    // 6: saturation of the narrow counters
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 32'h1000 + 32'(i * 16), 0, 0, 0, 0, 0);
      expect_ev(32'h2000, 1, 32'h1000 + 32'(i * 16), 32'h2000);
      step(0, 0, 0, 0, 0, 1, 1, 32'h2000);
    end
    drained("sat");
    cnts("sat", 10, 10, 7, 7);

    // reset while a decision is parked
    step(1, 0, 32'h1400, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1, 32'h1800);
    if_valid = 0;
    rst = 1'b1;
    #1;
    chk("rst held redirect", 32'(redirect), 0);
    chk("rst held btb_wen", 32'(btb_wen), 0);
    chk("rst held upd_target", btb_upd_target, 0);
    cnts("rst held", 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1, 32'h1800);
    rst = 1'b0;
    step(0, 1, 0, 0, 0, 1, 1, 32'h1800);
    step(0, 0, 0, 0, 0, 1, 1, 32'h1800);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    drained("post rst");
    cnts("post rst", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
